dummy_memory: RTL and testbench

DUMMY_MEMORY -- requirements
Module: dummy_memory

---
 rtl/dummy_memory.sv | 63 ++++++
 tb/tb_dummy_memory.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dummy_memory.sv
// Read-only triangle ROM with a registered output. Each address returns a synthetic triangle record in Q16.16.
// Define DUMMY_MEMORY_BOUND_EN to return all-zero records for addresses >= NUM_TRI.
module dummy_memory #(
    parameter int NUM_TRI = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic        [11:0] mem_addr,
    output logic signed [31:0] data_out [11:0]
);

    localparam logic signed [31:0] ONE_Q16 = 32'sh0001_0000;

`ifdef DUMMY_MEMORY_BOUND_EN
    localparam logic BOUND_EN = 1'b1;
`else
    localparam logic BOUND_EN = 1'b0;
`endif

    logic                keep_s;
    logic signed [31:0]  a_q16_s;
    logic signed [31:0]  next_s [11:0];
    logic signed [31:0]  data_r [11:0];

    // In the unbounded build NUM_TRI is still referenced, but it has no effect there.
    assign keep_s  = !BOUND_EN || ({20'd0, mem_addr} < NUM_TRI[31:0]);
    assign a_q16_s = {4'd0, mem_addr, 16'd0};

    // Build the record for the current address.
    always_comb begin
        for (int i = 0; i < 12; i++) begin
            next_s[i] = 32'sd0;
        end
        if (keep_s) begin
            next_s[0]  = ONE_Q16;
            next_s[3]  = a_q16_s;
            next_s[6]  = a_q16_s;
            next_s[7]  = ONE_Q16;
            next_s[9]  = a_q16_s;
            next_s[11] = ONE_Q16;
        end else begin
            for (int i = 0; i < 12; i++) begin
                next_s[i] = 32'sd0;
            end
        end
    end

    // Output register. Reset clears it asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 12; i++) begin
                data_r[i] <= 32'sd0;
            end
        end else begin
            for (int i = 0; i < 12; i++) begin
                data_r[i] <= next_s[i];
            end
        end
    end

    assign data_out = data_r;

endmodule

// File: tb/tb_dummy_memory.sv
// Self-checking bench for dummy_memory: a record-level reference model is checked every cycle, plus directed literal checks.
module tb_dummy_memory;

    localparam int NUM_TRI = 16;

    logic               clock;
    logic               reset;
    logic        [11:0] mem_addr;
    logic signed [31:0] data_out [11:0];

    int checks = 0;
    int errors = 0;

    int m_addr = 0;
    bit m_zero = 1'b1;

    dummy_memory #(.NUM_TRI(NUM_TRI)) dut (
        .clock    (clock),
        .reset    (reset),
        .mem_addr (mem_addr),
        .data_out (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected word of the record currently held for an address.
    function automatic int exp_word(int idx, int addr, bit zero);
        bit valid;
        valid = !zero;
`ifdef DUMMY_MEMORY_BOUND_EN
        if (addr >= NUM_TRI) valid = 1'b0;
`endif
        if (!valid) return 0;
        case (idx)
            0, 7, 11: return 65536;
            3, 6, 9:  return addr * 65536;
            default:  return 0;
        endcase
    endfunction

    // Model state: the address captured at the last edge, or the reset condition.
    always @(posedge clock) begin
        if (reset) m_zero = 1'b1;
        else begin
            m_zero = 1'b0;
            m_addr = int'(mem_addr);
        end
    end
    always @(posedge reset) m_zero = 1'b1;

    // Compare all words against the model on every falling edge.
    always @(negedge clock) begin
        int bad;
        bad = -1;
        for (int i = 0; i < 12; i++) begin
            if (bad < 0 && int'(data_out[i]) != exp_word(i, m_addr, m_zero)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL model word%0d at %0t: got %h expected %h", bad, $time,
                     data_out[bad], exp_word(bad, m_addr, m_zero));
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    initial begin
        reset    = 1'b1;
        mem_addr = 12'h000;
        repeat (2) @(negedge clock);
        check("rst_word0", data_out[0], 32'h0000_0000);
        check("rst_word11", data_out[11], 32'h0000_0000);
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_rst_word0", data_out[0], 32'h0001_0000);
        check("post_rst_word3", data_out[3], 32'h0000_0000);
        check("post_rst_word4", data_out[4], 32'h0000_0000);
        check("post_rst_word5", data_out[5], 32'h0000_0000);
        check("post_rst_word7", data_out[7], 32'h0001_0000);
        check("post_rst_word11", data_out[11], 32'h0001_0000);

        for (int a = 0; a < 16; a++) begin
            @(negedge clock);
            mem_addr = a[11:0];
            @(posedge clock); #1;
            check("step_word6", data_out[6], {4'd0, a[11:0], 16'd0});
            if (a == 5) check("step_addr5_word3", data_out[3], 32'h0005_0000);
            if (a == 15) check("step_addrF_word9", data_out[9], 32'h000F_0000);
            repeat (2) @(posedge clock);
            #1 check("hold_word3", data_out[3], {4'd0, a[11:0], 16'd0});
        end

        @(negedge clock);
        mem_addr = 12'h003;
        @(posedge clock); #1;
        mem_addr = 12'h004;
        #2 check("midcycle_old", data_out[3], 32'h0003_0000);
        @(posedge clock); #1;
        check("midcycle_new", data_out[3], 32'h0004_0000);

        @(negedge clock);
        mem_addr = 12'hFFF;
        @(posedge clock); #1;
`ifdef DUMMY_MEMORY_BOUND_EN
        check("fff_bounded_word0", data_out[0], 32'h0000_0000);
        check("fff_bounded_word3", data_out[3], 32'h0000_0000);
`else
        check("fff_word3", data_out[3], 32'h0FFF_0000);
        check("fff_word6", data_out[6], 32'h0FFF_0000);
        check("fff_word9", data_out[9], 32'h0FFF_0000);
`endif
        @(negedge clock);
        mem_addr = 12'h000;
        @(posedge clock); #1;
        check("wrap_word0", data_out[0], 32'h0001_0000);
        check("wrap_word3", data_out[3], 32'h0000_0000);

        @(negedge clock);
        mem_addr = 12'h007;
        @(posedge clock); #1;
        check("pre_async_word3", data_out[3], 32'h0007_0000);
        #2 reset = 1'b1;
        #1 check("async_word3", data_out[3], 32'h0000_0000);
        check("async_word0", data_out[0], 32'h0000_0000);
        @(negedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        check("post_async_word3", data_out[3], 32'h0007_0000);
        check("post_async_word0", data_out[0], 32'h0001_0000);

        repeat (2) @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
